// File: rtl/alu_muldiv_iter_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// mdOPType encoding keeps divide ops in bit 2 and remainder ops in bits 2 and 1.
package alu_muldiv_iter_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdOPType;

    function automatic logic is_div_op(mdOPType op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(mdOPType op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_iter_if.sv
// Request/response handshake bundle between the execute stage and the mul/div unit.
interface alu_muldiv_iter_if
    import alu_muldiv_iter_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    mdOPType         mdOP;
    logic [XLEN-1:0] inputA;
    logic [XLEN-1:0] inputB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            negative;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, mdOP, inputA, inputB, out_ready,
        input  in_ready, out_valid, result, negative, zero, busy
    );

    modport slave (
        input  in_valid, mdOP, inputA, inputB, out_ready,
        output in_ready, out_valid, result, negative, zero, busy
    );
endinterface

// File: rtl/alu_muldiv_iter_muldiv_step.sv
// One iteration over the 2*XLEN accumulator: shift-add multiply (multiplier in the
// low half, consumed LSB first) or restoring divide (remainder high, quotient low).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] trial;

    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        // Partial remainder shifted left with the next dividend bit; needs XLEN+1 bits.
        part  = acc[2*XLEN-1:XLEN-1];
        trial = part - {1'b0, opnd};
        if (is_div) begin
            if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else              acc_next = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on sign-stripped operands,
// sign restored in FIX, result held in DONE until the consumer takes it.
module alu_muldiv_iter
    import alu_muldiv_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    alu_muldiv_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int CW = $clog2(XLEN) + 1;

    state_t            state;
    mdOPType           op;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic              res_neg;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   result;
    logic              negative;
    logic              zero;
    logic              out_valid;
    logic              op_is_div;

    logic              a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] special_acc;

    // Accept-time decode: magnitudes, result sign and the CALC-bypass cases.
    always_comb begin
        a_sgn = bus.mdOP inside {MULH, MULHSU, DIV, REM};
        b_sgn = bus.mdOP inside {MULH, DIV, REM};
        a_neg = a_sgn & bus.inputA[XLEN-1];
        b_neg = b_sgn & bus.inputB[XLEN-1];
        mag_a = a_neg ? -bus.inputA : bus.inputA;
        mag_b = b_neg ? -bus.inputB : bus.inputB;
        div0  = is_div_op(bus.mdOP) && (bus.inputB == '0);
        ovf   = (bus.mdOP inside {DIV, REM}) && (&bus.inputB)
                && (bus.inputA == {1'b1, {(XLEN-1){1'b0}}});
        // Special results are preloaded where FIX will pick them up with no negation.
        if (div0)
            special_acc = is_rem_op(bus.mdOP) ? {bus.inputA, {XLEN{1'b0}}}
                                              : {{XLEN{1'b0}}, {XLEN{1'b1}}};
        else if (is_rem_op(bus.mdOP))
            special_acc = '0;
        else
            special_acc = {{XLEN{1'b0}}, bus.inputA};
    end

    assign op_is_div = is_div_op(op);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .is_div   (op_is_div),
        .acc_next (acc_next)
    );

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remd, fix_val;

    always_comb begin
        prod = res_neg ? -acc : acc;
        quo  = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remd = res_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            MUL:                 fix_val = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_val = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_val = quo;
            default:             fix_val = remd;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            op        <= MUL;
            acc       <= '0;
            opnd      <= '0;
            res_neg   <= 1'b0;
            count     <= '0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op    <= bus.mdOP;
                    count <= '0;
                    if (div0 || ovf) begin
                        acc     <= special_acc;
                        res_neg <= 1'b0;
                        state   <= FIX;
                    end else begin
                        acc     <= is_div_op(bus.mdOP) ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                        opnd    <= is_div_op(bus.mdOP) ? mag_b : mag_a;
                        res_neg <= is_rem_op(bus.mdOP) ? a_neg : (a_neg ^ b_neg);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    result    <= fix_val;
                    negative  <= fix_val[XLEN-1];
                    zero      <= (fix_val == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.negative  = negative;
    assign bus.zero      = zero;
endmodule

// File: doc/alu_muldiv_iter.md
# alu_muldiv_iter

Iterative, parametrised RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and computes it over XLEN+2 cycles using one bit per cycle (shift-add for multiply, restoring for divide). It returns the result with the same `negative`/`zero` flags the ALU produces. The core stalls on `in_ready` / `out_valid`.

## Interface
- `XLEN`, 32: operand and result width; must be ≥ 4.
- `clk`  input  1  system clock, rising-edge.
- `nrst`  input  1  reset, asynchronous, active-low.
- `flush`  input  1  synchronous abort of any in-flight operation.
- `in_valid`  input  1  request present.
- `in_ready`  output  1  unit can accept; high only in IDLE.
- `mdOP`  input  mdOPType  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `inputA`, `inputB`  input  XLEN  rs1, rs2 operands; captured at accept.
- `out_valid`  output  1  `result` and flags valid; held until taken.
- `out_ready`  input  1  consumer takes result.
- `result`  output  XLEN  registered result.
- `negative`  output  1  `result[XLEN-1]`.
- `zero`  output  1  `result == 0`.
- `busy`  output  1  state ≠ IDLE.

## Operation
- States:
  - IDLE → (accept) → CALC, or → FIX for special cases.
  - CALC → (count hits XLEN) → FIX.
  - FIX → DONE.
  - DONE → (`out_ready`) → IDLE.
- Accept happens when `in_valid && in_ready` on a rising edge. At accept the unit latches `mdOP`, the operand magnitudes and the sign flags:
  - Signed operand: MULH treats both operands as signed. MULHSU treats only A as signed. DIV/REM treat both as signed.
  - Unsigned operands (MUL, MULHU, DIVU, REMU) are used raw.
- CALC performs exactly XLEN iterations on a 2·XLEN-bit accumulator and a log2(XLEN)+1-bit counter.
- FIX applies two's-complement negation for the result sign, then selects the output:
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - DIV*: quotient.
  - REM*: remainder. The remainder sign follows the dividend.
- Special cases are detected at accept. They skip CALC and load the final value directly in FIX:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `inputA`.
  - Signed overflow (A = 2^(XLEN-1), B = −1): DIV → A; REM → 0.
- `flush` has priority over every transition. It forces IDLE and deasserts `out_valid` on the next edge; no result is produced.
- A new request is not accepted in the cycle `out_ready` is taken. `in_ready` rises the cycle after.
- Asynchronous reset puts state in IDLE and clears `result`, the accumulator and the counter. Reset values:
  - 0: `out_valid`, `result`, `negative`, `busy`.
  - 1: `zero`, `in_ready`.
- Reset mid-operation discards the operation entirely.

## Timing
- Accept at edge k. For a normal operation `out_valid` rises after edge k+XLEN+1, i.e. XLEN+2 cycles of latency (34 for XLEN=32).
- Special cases: `out_valid` rises after edge k+1 (2-cycle latency).
- `result`, `negative` and `zero` are registered and stable while `out_valid` is high. They change only on the FIX→DONE transition.
- `in_ready` and `busy` are combinational from state only; there is no combinational path from `in_valid` to `in_ready`.
- `out_valid` held with `out_ready` low keeps DONE indefinitely, with outputs frozen.

## Structure
- The `mdOPType` enum (3 bits, 8 values) goes in the shared CPU types package alongside `cuOPType`. The decoder maps CU M-extension ops onto it.
- The state enum (IDLE, CALC, FIX, DONE) stays local to the module.
- One sub-module is natural: `muldiv_step`. It is combinational, computes one shift-add or restore-subtract iteration over the 2·XLEN accumulator, and is parametrised by XLEN.

## Test plan
- MUL 7 × 6 → `result` = 42, `zero` = 0, `negative` = 0; `out_valid` exactly 34 cycles after accept.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000, `zero` = 1. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD, `negative` = 1. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, each with 2-cycle latency. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0, `zero` = 1.
- Backpressure: hold `out_ready` low for 10 cycles → `result` and `out_valid` stable and `in_ready` = 0. `in_valid` held high during that window is not accepted until the cycle after the result is taken.
- Abort:
  - `flush` at cycle 10 of CALC → IDLE next edge, no `out_valid`; an immediate MUL 3 × 3 then returns 9.
  - `nrst` pulsed low mid-CALC → all outputs at reset values within the same cycle.
- Repeat the MUL and DIV scenarios with XLEN = 16.
